// File: rtl/uart_cmd_decoder.sv
// ASCII-hex command parser sitting behind uart_rx: turns "Raaaa<CR|LF>" and
// "Waaaadddd<CR|LF>" byte streams into single-cycle bus requests.
module uart_cmd_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    output logic [15:0] addr_o,
    output logic [15:0] data_o,
    output logic        rw_o,
    output logic        valid_o,
    output logic        error_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam logic [7:0] CHAR_R  = 8'h52;
    localparam logic [7:0] CHAR_W  = 8'h57;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    function automatic logic is_hex(input logic [7:0] b);
        return ((b >= 8'h30) && (b <= 8'h39)) ||
               ((b >= 8'h41) && (b <= 8'h46)) ||
               ((b >= 8'h61) && (b <= 8'h66));
    endfunction

    // Letters A-F/a-f share their low nibble 1..6, so adding 9 yields 10..15.
    function automatic logic [3:0] hex_nib(input logic [7:0] b);
        logic [3:0] n;
        if (b <= 8'h39) begin
            n = b[3:0];
        end else begin
            n = b[3:0] + 4'd9;
        end
        return n;
    endfunction

    function automatic logic is_term(input logic [7:0] b);
        return (b == CHAR_CR) || (b == CHAR_LF);
    endfunction

    state_t      state_r, state_s;
    logic [31:0] buf_r, buf_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [3:0]  need_s;
    logic [15:0] addr_s, data_s;
    logic        rw_s, valid_s, error_s;

    // Next-state, shift buffer and registered-output next values
    always_comb begin
        state_s = state_r;
        buf_s   = buf_r;
        cnt_s   = cnt_r;
        addr_s  = addr_o;
        data_s  = data_o;
        rw_s    = rw_o;
        valid_s = 1'b0;
        error_s = 1'b0;
        need_s  = (state_r == ST_WRITE) ? 4'd8 : 4'd4;

        if (valid_i) begin
            case (state_r)
                ST_IDLE: begin
                    if (data_i == CHAR_R) begin
                        state_s = ST_READ;
                        cnt_s   = 4'd0;
                        buf_s   = 32'h0000_0000;
                    end else if (data_i == CHAR_W) begin
                        state_s = ST_WRITE;
                        cnt_s   = 4'd0;
                        buf_s   = 32'h0000_0000;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_READ, ST_WRITE: begin
                    if (is_hex(data_i) && (cnt_r < need_s)) begin
                        buf_s = {buf_r[27:0], hex_nib(data_i)};
                        cnt_s = cnt_r + 4'd1;
                    end else if (is_term(data_i) && (cnt_r == need_s)) begin
                        valid_s = 1'b1;
                        if (state_r == ST_READ) begin
                            addr_s = buf_r[15:0];
                            data_s = 16'h0000;
                            rw_s   = 1'b0;
                        end else begin
                            addr_s = buf_r[31:16];
                            data_s = buf_r[15:0];
                            rw_s   = 1'b1;
                        end
                        state_s = ST_IDLE;
                        cnt_s   = 4'd0;
                        buf_s   = 32'h0000_0000;
                    end else begin
                        // The offending byte is consumed here, never re-parsed.
                        error_s = 1'b1;
                        state_s = ST_IDLE;
                        cnt_s   = 4'd0;
                        buf_s   = 32'h0000_0000;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = 4'd0;
                    buf_s   = 32'h0000_0000;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Parser state and registered bus-request outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            buf_r   <= 32'h0000_0000;
            cnt_r   <= 4'd0;
            addr_o  <= 16'h0000;
            data_o  <= 16'h0000;
            rw_o    <= 1'b0;
            valid_o <= 1'b0;
            error_o <= 1'b0;
        end else begin
            state_r <= state_s;
            buf_r   <= buf_s;
            cnt_r   <= cnt_s;
            addr_o  <= addr_s;
            data_o  <= data_s;
            rw_o    <= rw_s;
            valid_o <= valid_s;
            error_o <= error_s;
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Randomised and directed bench for uart_cmd_decoder; a string-level command
// model predicts every strobe and output change with its cycle stamp.
module tb_uart_cmd_decoder;

    logic        clk;
    logic        rst_n;
    logic [7:0]  data_i;
    logic        valid_i;
    logic [15:0] addr_o;
    logic [15:0] data_o;
    logic        rw_o;
    logic        valid_o;
    logic        error_o;

    uart_cmd_decoder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (data_i),
        .valid_i (valid_i),
        .addr_o  (addr_o),
        .data_o  (data_o),
        .rw_o    (rw_o),
        .valid_o (valid_o),
        .error_o (error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event layout: {cycle[66:35], valid[34], error[33], rw[32], addr[31:16], data[15:0]}
    logic [66:0] obs_q[$];
    logic [66:0] exp_q[$];

    // Reference model: the command text collected so far (empty = idle)
    logic [7:0]  cur[$];
    logic [15:0] m_addr, m_data;
    logic        m_rw, m_valid, m_err;

    function automatic int hexval(input logic [7:0] b);
        if (b >= "0" && b <= "9") return int'(b) - 48;
        if (b >= "A" && b <= "F") return int'(b) - 55;
        if (b >= "a" && b <= "f") return int'(b) - 87;
        return -1;
    endfunction

    function automatic bit is_term(input logic [7:0] b);
        return (b == 8'h0D) || (b == 8'h0A);
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int n;
        int nd;
        longint v;
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (cur.size() == 0) begin
            if (b == "R" || b == "W") cur.push_back(b);
        end else begin
            n  = (cur[0] == "R") ? 4 : 8;
            nd = cur.size() - 1;
            if (hexval(b) >= 0 && nd < n) begin
                cur.push_back(b);
            end else if (is_term(b) && nd == n) begin
                v = 0;
                for (int i = 1; i <= n; i++) v = v * 16 + hexval(cur[i]);
                if (n == 4) begin
                    m_addr = 16'(v);
                    m_data = 16'h0000;
                    m_rw   = 1'b0;
                end else begin
                    m_addr = 16'(v / 65536);
                    m_data = 16'(v % 65536);
                    m_rw   = 1'b1;
                end
                m_valid = 1'b1;
                cur.delete();
            end else begin
                m_err = 1'b1;
                cur.delete();
            end
        end
    endtask

    // Record every strobe or change of the held outputs
    initial begin
        logic [32:0] prev;
        logic [32:0] now;
        prev = 33'd0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                now = {rw_o, addr_o, data_o};
                if (valid_o || error_o || now !== prev)
                    obs_q.push_back({32'(cyc), valid_o, error_o, now});
                prev = now;
            end
        end
    end

    // Called at posedge+1; drives one cycle of input and predicts its effect
    task automatic step(input bit v, input logic [7:0] b);
        logic [32:0] old;
        valid_i = v;
        data_i  = b;
        if (v) begin
            old = {m_rw, m_addr, m_data};
            model_byte(b);
            if (m_valid || m_err || {m_rw, m_addr, m_data} !== old)
                exp_q.push_back({32'(cyc + 1), m_valid, m_err, m_rw, m_addr, m_data});
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    // '.' stands for CR and '|' for LF
    task automatic send_str(input string s, input int gap);
        logic [7:0] c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (c == ".") c = 8'h0D;
            else if (c == "|") c = 8'h0A;
            step(1'b1, c);
            repeat (gap) step(1'b0, 8'($urandom));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid_i = 1'b0; data_i = 8'h00;
        m_addr = 16'h0000; m_data = 16'h0000; m_rw = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (addr_o !== 16'h0000) begin bad++; $display("FAIL reset_addr: got %h want 0000", addr_o); end
        total++; if (data_o !== 16'h0000) begin bad++; $display("FAIL reset_data: got %h want 0000", data_o); end
        total++; if (rw_o !== 1'b0) begin bad++; $display("FAIL reset_rw: got %b want 0", rw_o); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        total++; if (error_o !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", error_o); end
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step(1'b0, 8'h00);
    endtask

    task automatic test_read_spaced();
        obs_q.delete(); exp_q.delete();
        send_str("R1234.|", 9);
        repeat (3) step(1'b0, 8'h00);
        total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL read_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL read_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        total++; if (obs_q.size() !== 1) begin bad++; $display("FAIL read_pulses: got %0d want 1", obs_q.size()); end
        total++; if ({rw_o, addr_o, data_o} !== {1'b0, 16'h1234, 16'h0000}) begin bad++; $display("FAIL read_outputs: got %b/%h/%h want 0/1234/0000", rw_o, addr_o, data_o); end
    endtask

    task automatic test_back_to_back();
        obs_q.delete(); exp_q.delete();
        send_str("W12345678.Wbeefcafe|", 0);
        repeat (3) step(1'b0, 8'h00);
        total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        if (obs_q.size() == 2) begin
            total++; if (obs_q[0][34:0] !== {2'b10, 1'b1, 16'h1234, 16'h5678}) begin bad++; $display("FAIL b2b_first: got %h want 5_1234_5678", obs_q[0][34:0]); end
            total++; if (obs_q[1][34:0] !== {2'b10, 1'b1, 16'hBEEF, 16'hCAFE}) begin bad++; $display("FAIL b2b_second: got %h want 5_beef_cafe", obs_q[1][34:0]); end
        end else begin
            total++; bad++; $display("FAIL b2b_pulses: got %0d want 2", obs_q.size());
        end
    endtask

    task automatic test_hex_error();
        obs_q.delete(); exp_q.delete();
        send_str("R12G4.", 1);
        total++; if ({addr_o, data_o} !== {16'hBEEF, 16'hCAFE}) begin bad++; $display("FAIL hexerr_hold: got %h/%h want beef/cafe", addr_o, data_o); end
        send_str("R0001.", 1);
        repeat (2) step(1'b0, 8'h00);
        total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL hexerr_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL hexerr_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        if (obs_q.size() > 0) begin
            total++; if (obs_q[0][34:33] !== 2'b01) begin bad++; $display("FAIL hexerr_first: got %b want 01", obs_q[0][34:33]); end
        end
        total++; if ({rw_o, addr_o, data_o} !== {1'b0, 16'h0001, 16'h0000}) begin bad++; $display("FAIL hexerr_after: got %b/%h/%h want 0/0001/0000", rw_o, addr_o, data_o); end
    endtask

    task automatic test_length_errors();
        obs_q.delete(); exp_q.delete();
        send_str("R123.R12345.W1234|", 0);
        repeat (3) step(1'b0, 8'h00);
        total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL len_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL len_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        total++; if (obs_q.size() !== 3) begin bad++; $display("FAIL len_errors: got %0d want 3", obs_q.size()); end
        total++; if ({rw_o, addr_o, data_o} !== {1'b0, 16'h0001, 16'h0000}) begin bad++; $display("FAIL len_hold: got %b/%h/%h want 0/0001/0000", rw_o, addr_o, data_o); end
    endtask

    task automatic test_reset_mid();
        obs_q.delete(); exp_q.delete();
        send_str("R12", 1);
        rst_n = 1'b0;
        cur.delete();
        if ({m_rw, m_addr, m_data} !== 33'd0) exp_q.push_back({32'(cyc), 2'b00, 33'd0});
        m_addr = 16'h0000; m_data = 16'h0000; m_rw = 1'b0;
        repeat (3) step(1'b0, 8'h00);
        rst_n = 1'b1;
        send_str("34.", 1);
        total++; if ({rw_o, addr_o, data_o, valid_o, error_o} !== 35'd0) begin bad++; $display("FAIL rstmid_zero: got %b/%h/%h want all zero", rw_o, addr_o, data_o); end
        send_str("R00FF.", 0);
        repeat (2) step(1'b0, 8'h00);
        total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL rstmid_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rstmid_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        total++; if (addr_o !== 16'h00FF) begin bad++; $display("FAIL rstmid_addr: got %h want 00ff", addr_o); end
    endtask

    task automatic test_idle_noise();
        obs_q.delete(); exp_q.delete();
        send_str("xyz.|W00010002.", 0);
        repeat (2) step(1'b0, 8'h00);
        total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL noise_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL noise_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        total++; if ({rw_o, addr_o, data_o} !== {1'b1, 16'h0001, 16'h0002}) begin bad++; $display("FAIL noise_outputs: got %b/%h/%h want 1/0001/0002", rw_o, addr_o, data_o); end
    endtask

    task automatic test_random();
        string      hexch;
        logic [7:0] cmd[$];
        int         nd;
        hexch = "0123456789abcdefABCDEF";
        obs_q.delete(); exp_q.delete();
        for (int k = 0; k < 300; k++) begin
            cmd.delete();
            if ($urandom_range(0, 9) == 0) cmd.push_back(8'($urandom));
            cmd.push_back($urandom_range(0, 1) ? 8'h52 : 8'h57);
            nd = (cmd[cmd.size() - 1] == 8'h52) ? 4 : 8;
            case ($urandom_range(0, 9))
                0: nd = nd - 1;
                1: nd = nd + 1;
                default: nd = nd;
            endcase
            for (int d = 0; d < nd; d++) cmd.push_back(hexch[$urandom_range(0, 21)]);
            if ($urandom_range(0, 9) == 0) cmd.insert($urandom_range(1, cmd.size()), 8'($urandom));
            cmd.push_back($urandom_range(0, 1) ? 8'h0D : 8'h0A);
            if ($urandom_range(0, 2) == 0) cmd.push_back(8'h0A);
            foreach (cmd[j]) begin
                step(1'b1, cmd[j]);
                repeat ($urandom_range(0, 2)) step(1'b0, 8'($urandom));
            end
        end
        repeat (3) step(1'b0, 8'h00);
        total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_read_spaced();
        test_back_to_back();
        test_hex_error();
        test_length_errors();
        test_reset_mid();
        test_idle_noise();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
